// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one two-stage ALU among NREQ lanes, with optional
// per-lane grant lock and a tag pipeline that routes each result back to its lane.
module alu_issue_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned IDW      = 2,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [16*NREQ-1:0] req_ins,
    input  logic [16*NREQ-1:0] req_pc,
    input  logic [16*NREQ-1:0] req_op1,
    input  logic [16*NREQ-1:0] req_op2,
    output logic [NREQ-1:0]   req_ready,
    output logic [15:0]       alu_ins,
    output logic [15:0]       alu_pc,
    output logic [15:0]       alu_op1,
    output logic [15:0]       alu_op2,
    input  logic [15:0]       alu_x2_result,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [15:0]       resp_result,
    output logic              busy,
    output logic              lock_active
);

    localparam int unsigned CW = $clog2(MAX_LOCK + 1);

    typedef enum logic [0:0] {StUnlocked, StLocked} lock_state_e;

    lock_state_e    state_q, state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           force_q, force_d;
    logic           s1_valid_q, s2_valid_q;
    logic [IDW-1:0] s1_id_q, s2_id_q;

    logic           gnt_any;
    logic [IDW-1:0] gnt_id;
    logic           accept;

    // Descending scan so the lane closest after ptr is assigned last and wins.
    always_comb begin
        logic [IDW-1:0] cand;
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        if (en) begin
            if (state_q == StLocked) begin
                gnt_any = req_valid[owner_q];
                gnt_id  = owner_q;
            end else begin
                for (int k = int'(NREQ); k > 0; k--) begin
                    cand = IDW'((int'(ptr_q) + k) % int'(NREQ));
                    if (req_valid[cand]) begin
                        gnt_any = 1'b1;
                        gnt_id  = cand;
                    end
                end
            end
        end
    end

    assign accept = gnt_any;

    always_comb begin
        req_ready = '0;
        alu_ins   = '0;
        alu_pc    = '0;
        alu_op1   = '0;
        alu_op2   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_any && gnt_id == IDW'(i)) begin
                req_ready[i] = 1'b1;
                alu_ins      = req_ins[16*i +: 16];
                alu_pc       = req_pc[16*i +: 16];
                alu_op1      = req_op1[16*i +: 16];
                alu_op2      = req_op2[16*i +: 16];
            end
        end
    end

    // force_q marks the beat after a forced release: its lock bit must not re-lock.
    always_comb begin
        logic [CW-1:0] cnt_nxt;
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        force_d = force_q;
        cnt_nxt = '0;
        if (accept) begin
            force_d = 1'b0;
            if (req_lock[gnt_id] && !force_q) begin
                cnt_nxt = (state_q == StLocked) ? cnt_q + CW'(1) : CW'(1);
                if (cnt_nxt >= CW'(MAX_LOCK)) begin
                    state_d = StUnlocked;
                    cnt_d   = '0;
                    force_d = 1'b1;
                end else begin
                    state_d = StLocked;
                    owner_d = gnt_id;
                    cnt_d   = cnt_nxt;
                end
            end else begin
                state_d = StUnlocked;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StUnlocked;
            ptr_q      <= IDW'(NREQ - 1);
            owner_q    <= '0;
            cnt_q      <= '0;
            force_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            force_q    <= force_d;
            if (accept) begin
                ptr_q <= gnt_id;
            end
            s1_valid_q <= accept;
            s1_id_q    <= gnt_id;
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
        end
    end

    assign resp_valid  = s2_valid_q;
    assign resp_id     = s2_valid_q ? s2_id_q : '0;
    assign resp_result = s2_valid_q ? alu_x2_result : '0;
    assign busy        = s1_valid_q | s2_valid_q;
    assign lock_active = (state_q == StLocked);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter; a two-register adder stands in for the execute ALU.
module tb_alu_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  req_valid, req_lock, req_ready;
    logic [63:0] req_ins, req_pc, req_op1, req_op2;
    logic [15:0] alu_ins, alu_pc, alu_op1, alu_op2, alu_x2_result, resp_result;
    logic        resp_valid, busy, lock_active;
    logic [1:0]  resp_id;
    logic [15:0] x1, x2;

    int n_cmp  = 0;
    int n_fail = 0;

    int   g2 [6]  = '{3, 0, 1, 2, 3, 0};
    logic [3:0] r3 [7] = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
    logic lk3 [7] = '{0, 1, 1, 1, 1, 0, 0};
    logic lk4 [20] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1};

    always #5 clk = ~clk;

    alu_issue_arbiter #(.NREQ(4), .IDW(2), .MAX_LOCK(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .req_valid     (req_valid),
        .req_lock      (req_lock),
        .req_ins       (req_ins),
        .req_pc        (req_pc),
        .req_op1       (req_op1),
        .req_op2       (req_op2),
        .req_ready     (req_ready),
        .alu_ins       (alu_ins),
        .alu_pc        (alu_pc),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_x2_result (alu_x2_result),
        .resp_valid    (resp_valid),
        .resp_id       (resp_id),
        .resp_result   (resp_result),
        .busy          (busy),
        .lock_active   (lock_active)
    );

    always @(posedge clk) begin
        x1 <= alu_op1 + alu_op2;
        x2 <= x1;
    end
    assign alu_x2_result = x2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic v, input logic lk, input logic [15:0] a,
                            input logic [15:0] b);
        req_valid[i]         = v;
        req_lock[i]          = lk;
        req_ins[16*i +: 16]  = 16'h1000 * 16'(i);
        req_pc[16*i +: 16]   = 16'h0100 + 16'h0010 * 16'(i);
        req_op1[16*i +: 16]  = a;
        req_op2[16*i +: 16]  = b;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1;
        req_valid = '0; req_lock = '0; req_ins = '0; req_pc = '0; req_op1 = '0; req_op2 = '0;

        // Reset state
        repeat (2) cyc();
        #3;
        chk("rst_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_result", resp_result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lock", lock_active, 0);
        chk("rst_alu_ins", alu_ins, 0);

        // 1: single lane 2 beat, 5+7
        cyc();
        rst_n = 1'b1;
        set_lane(2, 1'b1, 1'b0, 16'd5, 16'd7);
        #3;
        chk("t1_ready", req_ready, 4'b0100);
        chk("t1_op1", alu_op1, 16'd5);
        chk("t1_op2", alu_op2, 16'd7);
        chk("t1_pc", alu_pc, 16'h0120);
        chk("t1_ins", alu_ins, 16'h2000);
        chk("t1_busy0", busy, 0);
        cyc();
        set_lane(2, 1'b0, 1'b0, 16'd0, 16'd0);
        #3;
        chk("t1_ready_off", req_ready, 0);
        chk("t1_bubble_op1", alu_op1, 0);
        chk("t1_busy1", busy, 1);
        chk("t1_resp_early", resp_valid, 0);
        cyc(); #3;
        chk("t1_resp_valid", resp_valid, 1);
        chk("t1_resp_id", resp_id, 2);
        chk("t1_resp_result", resp_result, 16'd12);
        chk("t1_busy2", busy, 1);
        cyc(); #3;
        chk("t1_resp_done", resp_valid, 0);
        chk("t1_busy_done", busy, 0);

        // 2: all lanes valid, ptr=2 so rotation starts at lane 3
        for (int k = 0; k < 8; k++) begin
            cyc();
            for (int i = 0; i < 4; i++) set_lane(i, k < 6, 1'b0, 16'(i + 1), 16'd100);
            #3;
            if (k < 6) chk($sformatf("t2_ready_%0d", k), req_ready, 32'(1) << g2[k]);
            else       chk($sformatf("t2_ready_%0d", k), req_ready, 0);
            if (k >= 2) begin
                chk($sformatf("t2_rv_%0d", k), resp_valid, 1);
                chk($sformatf("t2_rid_%0d", k), resp_id, 32'(g2[k-2]));
                chk($sformatf("t2_res_%0d", k), resp_result, 32'(101 + g2[k-2]));
            end
        end

        // 3: lane 1 locks, idles one cycle while locked, releases; lanes 0/3 wait
        for (int k = 0; k < 7; k++) begin
            cyc();
            set_lane(0, 1'b1, 1'b0, 16'd1, 16'd0);
            set_lane(3, 1'b1, 1'b0, 16'd4, 16'd0);
            set_lane(1, k != 1 && k <= 4, k <= 3, 16'd2, 16'd0);
            #3;
            chk($sformatf("t3_ready_%0d", k), req_ready, r3[k]);
            chk($sformatf("t3_lock_%0d", k), lock_active, lk3[k]);
        end

        // 4: lane 0 lock held; forced release at MAX_LOCK, then lock bit ignored once
        for (int k = 0; k < 20; k++) begin
            cyc();
            for (int i = 1; i < 4; i++) set_lane(i, 1'b0, 1'b0, 16'd0, 16'd0);
            set_lane(0, 1'b1, 1'b1, 16'd3, 16'd4);
            set_lane(2, k >= 1 && k <= 8, 1'b0, 16'd9, 16'd9);
            if (k == 17) set_lane(2, 1'b0, 1'b0, 16'd0, 16'd0);
            #3;
            chk($sformatf("t4_ready_%0d", k), req_ready, (k == 8) ? 4'b0100 : 4'b0001);
            chk($sformatf("t4_lock_%0d", k), lock_active, lk4[k]);
        end

        // 5: drain with en=0 while locked by lane 0
        for (int k = 0; k < 5; k++) begin
            cyc();
            en = 1'b0;
            for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 1'b0, 16'(i + 1), 16'd100);
            #3;
            chk($sformatf("t5_ready_%0d", k), req_ready, 0);
            chk($sformatf("t5_lock_%0d", k), lock_active, 1);
            chk($sformatf("t5_rv_%0d", k), resp_valid, k < 2);
            chk($sformatf("t5_busy_%0d", k), busy, k < 2);
            if (k < 2) chk($sformatf("t5_res_%0d", k), resp_result, 16'd7);
        end
        cyc();
        en = 1'b1;
        #3;
        chk("t5_owner_first", req_ready, 4'b0001);
        chk("t5_still_locked", lock_active, 1);
        cyc(); #3;
        chk("t5_rr_after", req_ready, 4'b0010);
        chk("t5_unlocked", lock_active, 0);

        // 6: reset one cycle after accept discards in-flight tags
        cyc();
        rst_n = 1'b0;
        req_valid = '0;
        #3;
        chk("t6_rv_inrst", resp_valid, 0);
        chk("t6_busy_inrst", busy, 0);
        cyc();
        rst_n = 1'b1;
        req_valid = 4'b1111;
        #3;
        chk("t6_rv_t2", resp_valid, 0);
        chk("t6_first_grant", req_ready, 4'b0001);
        cyc(); #3;
        chk("t6_second_grant", req_ready, 4'b0010);
        cyc(); #3;
        chk("t6_resp_after", resp_valid, 1);
        chk("t6_resp_id", resp_id, 0);
        chk("t6_resp_result", resp_result, 16'd101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
